sevenseg_scan_display: RTL
==========================

# sevenseg_scan_display

Parametrised successor to the four-digit seven-segment driver, used on the motor board to show a decimal measurement (current in mA) and a direction character. It accepts a binary value on a load strobe and converts it to BCD sequentially (shift-add-3, one bit per cycle). It latches the result atomically, then time-multiplexes NUM_DIGITS common-anode digits. Over the old driver it adds: configurable digit count, width and refresh rate; leading-zero blanking; overflow indication; inter-digit anti-ghost blanking.

## Interface
- NUM_DIGITS, 4: total digits; the leftmost shows direction, the other NUM_DIGITS-1 are numeric.
- VALUE_W, 16: width of binary input.
- REFRESH_DIV_W, 18: each digit slot lasts 2^REFRESH_DIV_W clk cycles (2.62 ms at 100 MHz).
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off; must be < 2^REFRESH_DIV_W.
- clk  input  1  100 MHz system clock.
- rst  input  1  reset, synchronous, active-high.
- value_in  input  VALUE_W  unsigned binary value to display.
- load  input  1  single-cycle request to convert and display value_in.
- dir  input  1  0 = forward ("F"), 1 = reverse ("r"); live, not latched.
- blank_lz  input  1  1 = blank numeric leading zeros; live.
- busy  output  1  conversion in progress.
- SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  output  1  decimal point, active-low; constant 1 (off).
- AN  output  NUM_DIGITS  anodes, active-low; AN[0] is the rightmost digit.

## Operation
- **Converter states.**
  - IDLE: load=1 latches value_in, sets the overflow flag if value_in ≥ 10^(NUM_DIGITS-1) and goes to CONV. load=0 does nothing.
  - CONV: VALUE_W shift steps. On the last step the display register (numeric BCD digits plus overflow flag) is written and the state returns to IDLE.
  - load while in CONV is ignored, not queued.
- **Conversion arithmetic.**
  - BCD register is 4*(NUM_DIGITS-1) bits.
  - Each step: add 3 to every digit ≥5, then shift left one bit with the next MSB of the latched value entering.
  - Carries out of the top digit are discarded, so the result equals value mod 10^(NUM_DIGITS-1).
- **Scan.**
  - A refresh counter of REFRESH_DIV_W bits free-runs.
  - When it wraps to 0, the digit index increments, going NUM_DIGITS-1 → 0.
  - While the counter < BLANK_CYC: AN = all ones and SEG = 7'b1111111.
  - Otherwise: AN = ~(1 << index).
- **Digit content.**
  - Index NUM_DIGITS-1: "r" 7'b0101111 if dir=1, else "F" 7'b0001110.
  - Numeric index k: the BCD digit k, mapped to the standard 0–9 patterns.
  - Overflow flag set: every numeric digit shows "-" 7'b0111111, regardless of blank_lz.
  - blank_lz=1: numeric digits above the most significant non-zero digit show 7'b1111111. Digit 0 is never blanked.
- **Reset.** Converter to IDLE, busy=0, display register all zeros, overflow=0, refresh counter 0, index 0. With BLANK_CYC>0, AN = all ones and SEG = 7'b1111111; DP=1.

## Timing
- load=1 sampled at edge E0: busy=1 after E0.
- Shifts occur at E1..E_VALUE_W. The display register updates and busy=0 after E_VALUE_W, so busy stays high for exactly VALUE_W cycles.
- load may be re-accepted at the edge where busy falls (E_VALUE_W+1 sampling). There are no idle bubbles needed.
- The displayed numeric content changes only at the update edge; no partially converted digit is ever visible.
- dir and blank_lz affect SEG combinationally within the current slot, with zero latency.
- rst mid-conversion aborts it. The display register is cleared and does not keep the old value.
- Frame period = NUM_DIGITS·2^REFRESH_DIV_W cycles.

## Structure
- **sevenseg_pkg:**
  - segment constants SEG_DIGIT[0:9], SEG_R, SEG_F, SEG_DASH, SEG_BLANK;
  - function bcd_to_seg;
  - converter state enum {IDLE, CONV}.
- **Sub-module bin2bcd_seq:** parameters VALUE_W and BCD_DIGITS; ports clk, rst, start, bin, busy, done (1-cycle), bcd. It owns the shift-add-3 datapath and the step counter.
- The top level owns the overflow compare (constant 10^(NUM_DIGITS-1)), the display register, the scan counter, blanking and segment muxing.

## Test plan
Bench uses REFRESH_DIV_W=4 and BLANK_CYC=2.
- **Reset.** Hold rst 3 cycles → busy=0, AN=4'b1111 for 2 cycles, then AN=4'b1110 with SEG=7'b1000000 ("0").
- **Basic conversion.** load value_in=16'd472 → busy high exactly 16 cycles. Then digits 2/1/0 show "4","7","2"; dir=0 gives digit 3 = "F"; dir=1 switches it to "r" in the same slot.
- **Overflow.** load 16'd1000 and 16'd65535 → all numeric digits show "-". load 16'd999 → "9","9","9".
- **Leading zeros.** value 16'd7 with blank_lz=1 → digits 2,1 = 7'b1111111, digit 0 = "7". Value 0 → digit 0 = "0".
- **Busy and reset interaction.**
  - A second load during busy (value 123 after 456) is ignored → display 456.
  - A load on the cycle busy falls is accepted.
  - rst at shift 8 → busy=0 and the display shows all zeros.
- **Scan wrap.** Over 4·16 cycles, each AN bit is low exactly 14 consecutive cycles, in order AN[0]→AN[3]→AN[0].

Source files
------------

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: segment encodings, digit decoder and converter state type
package sevenseg_pkg;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  typedef enum logic {IDLE, CONV} conv_state_e;
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    return (d > 4'd9) ? SEG_BLANK : SEG_DIGIT[d];
  endfunction
endpackage

// File: rtl/sevenseg_scan_display_bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter, one bit per cycle
module bin2bcd_seq #(
  parameter int VALUE_W    = 16,
  parameter int BCD_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VALUE_W-1:0]      bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);
  import sevenseg_pkg::*;
  localparam int BW = 4 * BCD_DIGITS;
  localparam int CW = $clog2(VALUE_W + 1);
  localparam logic [CW-1:0] LAST = CW'(VALUE_W - 1);
  conv_state_e state_q, state_d;
  logic [VALUE_W-1:0] val_q, val_d;
  logic [BW-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  // Step datapath: done and bcd are combinational so the result can be captured on the final shift edge
  always_comb begin
    state_d = state_q;
    val_d = val_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    done = 1'b0;
    adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++)
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    if (state_q == IDLE) begin
      if (start) begin
        state_d = CONV;
        val_d = bin;
        bcd_d = '0;
        cnt_d = '0;
      end
    end else begin
      bcd_d = {adj[BW-2:0], val_q[VALUE_W-1]};
      val_d = val_q << 1;
      cnt_d = cnt_q + 1'b1;
      done = (cnt_q == LAST);
      state_d = done ? IDLE : CONV;
    end
  end
  // Converter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      val_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      val_q <= val_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end
  assign busy = (state_q == CONV);
  assign bcd = bcd_d;
endmodule

// File: rtl/sevenseg_scan_display.sv
// sevenseg_scan_display: multiplexed seven-segment driver with sequential BCD conversion
module sevenseg_scan_display #(
  parameter int NUM_DIGITS    = 4,
  parameter int VALUE_W       = 16,
  parameter int REFRESH_DIV_W = 18,
  parameter int BLANK_CYC     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value_in,
  input  logic                  load,
  input  logic                  dir,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic [6:0]            SEG,
  output logic                  DP,
  output logic [NUM_DIGITS-1:0] AN
);
  import sevenseg_pkg::*;
  localparam int BD = NUM_DIGITS - 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [63:0] OVF_LIM = 64'(10 ** BD);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [REFRESH_DIV_W-1:0] BLANK_LIM = REFRESH_DIV_W'(BLANK_CYC);
  logic done;
  logic [4*BD-1:0] bcd, disp_q, disp_d;
  logic ovf_q, ovf_d, dovf_q, dovf_d, nz, blank;
  logic [REFRESH_DIV_W-1:0] ref_q, ref_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [6:0] seg_all [0:NUM_DIGITS-1];
  bin2bcd_seq #(.VALUE_W(VALUE_W), .BCD_DIGITS(BD)) u_conv (
    .clk(clk), .rst(rst), .start(load), .bin(value_in),
    .busy(busy), .done(done), .bcd(bcd)
  );
  // Overflow is judged at load time and committed to the display together with the digits
  always_comb begin
    ovf_d = (load && !busy) ? (64'(value_in) >= OVF_LIM) : ovf_q;
    disp_d = done ? bcd : disp_q;
    dovf_d = done ? ovf_q : dovf_q;
    ref_d = ref_q + 1'b1;
    idx_d = (ref_q == '1) ? ((idx_q == LAST_IDX) ? '0 : idx_q + 1'b1) : idx_q;
  end
  // Display register and scan counters
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      disp_q <= '0;
      dovf_q <= 1'b0;
      ref_q <= '0;
      idx_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      disp_q <= disp_d;
      dovf_q <= dovf_d;
      ref_q <= ref_d;
      idx_q <= idx_d;
    end
  end
  // Per-digit patterns, scanning from the top numeric digit down to find leading zeros
  always_comb begin
    seg_all = '{default: SEG_BLANK};
    nz = 1'b0;
    seg_all[NUM_DIGITS-1] = dir ? SEG_R : SEG_F;
    for (int k = BD - 1; k >= 0; k--) begin
      nz = nz | (disp_q[4*k +: 4] != 4'd0);
      seg_all[k] = dovf_q ? SEG_DASH :
                   (blank_lz && !nz && k != 0) ? SEG_BLANK : bcd_to_seg(disp_q[4*k +: 4]);
    end
  end
  assign blank = (ref_q < BLANK_LIM);
  assign AN = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
  assign SEG = blank ? SEG_BLANK : seg_all[idx_q];
  assign DP = 1'b1;
endmodule
